mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the processor's single synchronous memory port (12-bit address, 16-bit data) between three requesters: instruction fetch (F), load/store data access (D) and a host loader/debug port (H).
- Sits between the pipeline stages and the memory macro, and drives the m_addr/m_data/m_rw/m_q interface.
- Runs one transaction at a time. Default priority is D > H > F, with an optional host burst lock and an anti-starvation override for fetch.

Parameters:
- ADDR_W, 12: memory address width.
- DATA_W, 16: memory data width.
- MEM_LATENCY, 1: cycles from address issue to m_q valid (range 1-7).
- STARVE_LIMIT, 4: consecutive lost arbitrations after which F wins. 0 disables the override.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- f_req  in  1  fetch read request.
- f_addr  in  ADDR_W  fetch address.
- f_gnt  out  1  one-cycle pulse: fetch request accepted.
- f_valid  out  1  one-cycle pulse: fetch rdata valid.
- d_req  in  1  data request.
- d_we  in  1  data write enable (1 = store).
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  data accepted pulse.
- d_valid  out  1  data completion pulse.
- h_req  in  1  host request.
- h_we  in  1  host write enable.
- h_addr  in  ADDR_W  host address.
- h_wdata  in  DATA_W  host write data.
- h_lock  in  1  host requests burst ownership.
- h_gnt  out  1  host accepted pulse.
- h_valid  out  1  host completion pulse.
- rdata  out  DATA_W  read data, shared; qualified by the x_valid pulses.
- m_addr  out  ADDR_W  memory address.
- m_data  out  DATA_W  memory write data.
- m_rw  out  1  memory write strobe (1 = write).
- m_q  in  DATA_W  memory read data.

Behaviour:

States and transitions:
- IDLE → ISSUE when any req is sampled high.
- ISSUE → WAIT.
- WAIT lasts MEM_LATENCY-1 extra cycles (0 when MEM_LATENCY = 1), then → DONE.
- DONE → IDLE. DONE also acts as an arbitration cycle (see Timing).

Timing (MEM_LATENCY = 1):
- Request sampled in cycle 0 (IDLE).
- ISSUE in cycle 1: m_addr, m_data and m_rw are driven, and the winner's gnt = 1.
- m_q is captured at the end of cycle 1+MEM_LATENCY.
- In cycle 2+MEM_LATENCY the winner's valid = 1 and rdata holds the captured value.
- That valid cycle is also an arbitration cycle, so back-to-back issue spacing is MEM_LATENCY+2 cycles.

Request rules:
- Requests are sampled only in arbitration cycles. A requester holds req/addr/we/wdata stable until its gnt.
- A request withdrawn before gnt is silently dropped.
- A req still high in the gnt cycle is not re-sampled; the requester must drop req at gnt unless it wants another transfer.

Memory port:
- m_rw = 1 only during ISSUE of a write; 0 in every other cycle.
- m_addr and m_data hold their last value outside ISSUE.
- For writes, valid still pulses at the read-equivalent time and rdata is unchanged.

Priority, in order of precedence:
1. Starvation override. The counter starve_cnt (saturating) increments in each arbitration cycle where f_req = 1 and F loses. It clears when F is granted. When starve_cnt ≥ STARVE_LIMIT (and the limit ≠ 0), F wins, overriding both lock and D.
2. Lock. Set when H is granted with h_lock = 1. While set, H beats D. Cleared in any arbitration cycle where h_lock = 0 or h_req = 0; in that cycle normal priority applies.
3. Default order: D > H > F.

Reset:
- Outputs: all gnt/valid = 0, m_rw = 0, m_addr = 0, m_data = 0, rdata = 0.
- Internal: starve_cnt = 0, lock = 0, state = IDLE.
- Reset asserted mid-transaction aborts it: no valid is ever emitted for it, and m_rw is 0 from the cycle after reset is sampled.
- The first arbitration after reset deassertion occurs in the first cycle reset is low.

Other boundaries:
- At most one gnt and one valid are high in any cycle.
- An address at the top of the range (0xFFF) passes through unmodified; there is no address arithmetic.

Decomposition:
- Package mem_arb_pkg:
  - state enum {IDLE, ISSUE, WAIT, DONE};
  - requester ID encoding REQ_NONE=0, REQ_F=1, REQ_D=2, REQ_H=3;
  - starve counter width constant (3 bits).
- One combinational sub-module, mem_arb_pick:
  - inputs: three reqs, lock, starve flag;
  - output: winner ID.
- FSM, latency counter, capture registers and the starve counter stay in mem_arbiter.

Test Plan:
1. Fetch read, mem[0x005] = 0xBEEF, f_req at cycle 0 → f_gnt at cycle 1 with m_addr = 0x005, m_rw = 0; f_valid at cycle 3 with rdata = 0xBEEF.
2. Data write, d_we = 1, d_addr = 0x0A0, d_wdata = 0x1234 → m_rw = 1 for exactly cycle 1 with m_addr = 0x0A0, m_data = 0x1234; d_valid at cycle 3. A following F read of 0x0A0 returns 0x1234.
3. f_req, d_req, h_req all raised at cycle 0 and each dropped at its gnt → grant order D, H, F at cycles 1, 4, 7.
4. STARVE_LIMIT = 2, d_req reasserted continuously, f_req held → grant sequence D, D, F, D; starve_cnt returns to 0 after the F grant.
5. h_lock = 1 with h_req held for 4 transfers while d_req is held → 4 consecutive H grants (cycles 1, 4, 7, 10); D granted at cycle 13 after h_lock drops.
6. MEM_LATENCY = 3, D read issued, reset pulsed in the WAIT cycle → no d_valid, m_rw = 0, all outputs at reset values; a new F read afterwards completes normally with valid 5 cycles after its request.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory arbiter: FSM states, requester IDs and
// the width of the fetch starvation counter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_F    = 2'd1,
        REQ_D    = 2'd2,
        REQ_H    = 2'd3
    } req_id_t;

    localparam int STARVE_W = 3;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection for one arbitration cycle.
// Precedence: starved fetch, then locked host, then D > H > F.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic    f_req,
    input  logic    d_req,
    input  logic    h_req,
    input  logic    lock,
    input  logic    starve,
    output req_id_t winner
);

    // Pick the highest-precedence active requester.
    always_comb begin
        winner = REQ_NONE;
        if (starve && f_req) begin
            winner = REQ_F;
        end else if (lock && h_req) begin
            winner = REQ_H;
        end else if (d_req) begin
            winner = REQ_D;
        end else if (h_req) begin
            winner = REQ_H;
        end else if (f_req) begin
            winner = REQ_F;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Three-way arbiter for the single synchronous memory port.
//
// Handshake: a requester raises x_req with its addr/we/wdata and holds
// them stable until it sees the one-cycle x_gnt pulse. Requests are only
// sampled in arbitration cycles (IDLE and DONE), so a req still high in
// the gnt cycle is not taken again; the requester drops it at gnt unless
// it wants another transfer. x_valid pulses once per granted transfer,
// MEM_LATENCY+1 cycles after gnt; for reads rdata is valid with it, for
// writes rdata keeps its previous value. There is no backpressure on
// gnt/valid.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 16,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                f_req,
    input  logic [ADDR_W-1:0]   f_addr,
    output logic                f_gnt,
    output logic                f_valid,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic                d_valid,
    input  logic                h_req,
    input  logic                h_we,
    input  logic [ADDR_W-1:0]   h_addr,
    input  logic [DATA_W-1:0]   h_wdata,
    input  logic                h_lock,
    output logic                h_gnt,
    output logic                h_valid,
    output logic [DATA_W-1:0]   rdata,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_data,
    output logic                m_rw,
    input  logic [DATA_W-1:0]   m_q,
    output state_t              dbg_state,
    output logic [STARVE_W-1:0] dbg_starve_cnt
);

    state_t              state;
    req_id_t             owner;
    logic                owner_we;
    logic [2:0]          lat_cnt;
    logic [STARVE_W-1:0] starve_cnt;
    logic                lock;

    req_id_t             winner;
    logic                starve_hit;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_data;
    logic                win_we;

    assign dbg_state      = state;
    assign dbg_starve_cnt = starve_cnt;

    // Fetch is forced through once it has lost STARVE_LIMIT arbitrations.
    assign starve_hit = (STARVE_LIMIT != 0) && (int'(starve_cnt) >= STARVE_LIMIT);

    // The lock only holds while the host keeps both h_req and h_lock up.
    mem_arb_pick u_pick (
        .f_req  (f_req),
        .d_req  (d_req),
        .h_req  (h_req),
        .lock   (lock && h_lock),
        .starve (starve_hit),
        .winner (winner)
    );

    // Route the winner's address, data and direction to the memory port.
    always_comb begin
        win_addr = f_addr;
        win_data = m_data;
        win_we   = 1'b0;
        case (winner)
            REQ_D: begin
                win_addr = d_addr;
                win_data = d_wdata;
                win_we   = d_we;
            end
            REQ_H: begin
                win_addr = h_addr;
                win_data = h_wdata;
                win_we   = h_we;
            end
            default: ;
        endcase
    end

    // Transaction FSM with registered strobes, capture and arbitration state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= REQ_NONE;
            owner_we   <= 1'b0;
            lat_cnt    <= '0;
            starve_cnt <= '0;
            lock       <= 1'b0;
            f_gnt      <= 1'b0;
            d_gnt      <= 1'b0;
            h_gnt      <= 1'b0;
            f_valid    <= 1'b0;
            d_valid    <= 1'b0;
            h_valid    <= 1'b0;
            rdata      <= '0;
            m_addr     <= '0;
            m_data     <= '0;
            m_rw       <= 1'b0;
        end else begin
            f_gnt   <= 1'b0;
            d_gnt   <= 1'b0;
            h_gnt   <= 1'b0;
            f_valid <= 1'b0;
            d_valid <= 1'b0;
            h_valid <= 1'b0;
            m_rw    <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (winner != REQ_NONE) begin
                        state    <= ISSUE;
                        owner    <= winner;
                        owner_we <= win_we;
                        m_addr   <= win_addr;
                        m_data   <= win_data;
                        m_rw     <= win_we;
                        f_gnt    <= (winner == REQ_F);
                        d_gnt    <= (winner == REQ_D);
                        h_gnt    <= (winner == REQ_H);
                        if (winner == REQ_F) begin
                            starve_cnt <= '0;
                        end else if (f_req && (starve_cnt != '1)) begin
                            starve_cnt <= starve_cnt + STARVE_W'(1);
                        end
                        if (winner == REQ_H) begin
                            lock <= h_lock;
                        end else if (!h_lock || !h_req) begin
                            lock <= 1'b0;
                        end
                    end else begin
                        // Nobody asking means h_req is low, so the lock drops.
                        state <= IDLE;
                        lock  <= 1'b0;
                    end
                end
                ISSUE: begin
                    state   <= WAIT;
                    lat_cnt <= 3'(MEM_LATENCY - 1);
                end
                WAIT: begin
                    if (lat_cnt == 3'd0) begin
                        state   <= DONE;
                        f_valid <= (owner == REQ_F);
                        d_valid <= (owner == REQ_D);
                        h_valid <= (owner == REQ_H);
                        if (!owner_we) begin
                            rdata <= m_q;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: dut_a (MEM_LATENCY=1, STARVE_LIMIT=2) covers the
// arbitration scenarios, dut_b (MEM_LATENCY=3) covers reset abort.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 12;
  localparam int DW = 16;

  typedef struct packed {
    logic                f_gnt;
    logic                f_valid;
    logic                d_gnt;
    logic                d_valid;
    logic                h_gnt;
    logic                h_valid;
    logic [DW-1:0]       rdata;
    logic [AW-1:0]       m_addr;
    logic [DW-1:0]       m_data;
    logic                m_rw;
    state_t              st;
    logic [STARVE_W-1:0] starve;
  } obs_t;

  typedef struct {
    req_id_t       id;
    int            rel;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          rw;
    logic [2:0]    starve;
  } glog_t;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- stimulus signals ----------------
  logic          sel;
  logic          f_req, d_req, h_req, d_we, h_we, h_lock;
  logic [AW-1:0] f_addr, d_addr, h_addr;
  logic [DW-1:0] d_wdata, h_wdata;
  logic          bd_we;
  logic [AW-1:0] bd_addr;
  logic [DW-1:0] bd_data;

  logic f_req_a, d_req_a, h_req_a, f_req_b, d_req_b, h_req_b;
  assign f_req_a = f_req & ~sel;
  assign d_req_a = d_req & ~sel;
  assign h_req_a = h_req & ~sel;
  assign f_req_b = f_req & sel;
  assign d_req_b = d_req & sel;
  assign h_req_b = h_req & sel;

  logic f_gnt_a, f_valid_a, d_gnt_a, d_valid_a, h_gnt_a, h_valid_a, m_rw_a;
  logic f_gnt_b, f_valid_b, d_gnt_b, d_valid_b, h_gnt_b, h_valid_b, m_rw_b;
  logic [DW-1:0] rdata_a, m_data_a, m_q_a, rdata_b, m_data_b, m_q_b;
  logic [AW-1:0] m_addr_a, m_addr_b;
  state_t st_a, st_b;
  logic [STARVE_W-1:0] stv_a, stv_b;

  obs_t oa, ob, os;
  assign oa = '{f_gnt: f_gnt_a, f_valid: f_valid_a, d_gnt: d_gnt_a, d_valid: d_valid_a,
                h_gnt: h_gnt_a, h_valid: h_valid_a, rdata: rdata_a, m_addr: m_addr_a,
                m_data: m_data_a, m_rw: m_rw_a, st: st_a, starve: stv_a};
  assign ob = '{f_gnt: f_gnt_b, f_valid: f_valid_b, d_gnt: d_gnt_b, d_valid: d_valid_b,
                h_gnt: h_gnt_b, h_valid: h_valid_b, rdata: rdata_b, m_addr: m_addr_b,
                m_data: m_data_b, m_rw: m_rw_b, st: st_b, starve: stv_b};
  assign os = sel ? ob : oa;

  mem_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(2)) dut_a (
    .clock(clock), .reset(reset),
    .f_req(f_req_a), .f_addr(f_addr), .f_gnt(f_gnt_a), .f_valid(f_valid_a),
    .d_req(d_req_a), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt_a), .d_valid(d_valid_a),
    .h_req(h_req_a), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_lock(h_lock), .h_gnt(h_gnt_a), .h_valid(h_valid_a),
    .rdata(rdata_a), .m_addr(m_addr_a), .m_data(m_data_a), .m_rw(m_rw_a),
    .m_q(m_q_a), .dbg_state(st_a), .dbg_starve_cnt(stv_a)
  );

  mem_arbiter #(.MEM_LATENCY(3), .STARVE_LIMIT(4)) dut_b (
    .clock(clock), .reset(reset),
    .f_req(f_req_b), .f_addr(f_addr), .f_gnt(f_gnt_b), .f_valid(f_valid_b),
    .d_req(d_req_b), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt_b), .d_valid(d_valid_b),
    .h_req(h_req_b), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_lock(h_lock), .h_gnt(h_gnt_b), .h_valid(h_valid_b),
    .rdata(rdata_b), .m_addr(m_addr_b), .m_data(m_data_b), .m_rw(m_rw_b),
    .m_q(m_q_b), .dbg_state(st_b), .dbg_starve_cnt(stv_b)
  );

  // ---------------- memory models ----------------
  logic [DW-1:0] mem_a [0:4095];
  logic [DW-1:0] mem_b [0:4095];
  logic [DW-1:0] q_b0, q_b1;

  always @(posedge clock) begin
    if (bd_we) mem_a[bd_addr] <= bd_data;
    else if (m_rw_a) mem_a[m_addr_a] <= m_data_a;
    m_q_a <= mem_a[m_addr_a];
  end

  always @(posedge clock) begin
    if (bd_we) mem_b[bd_addr] <= bd_data;
    else if (m_rw_b) mem_b[m_addr_b] <= m_data_b;
    q_b0  <= mem_b[m_addr_b];
    q_b1  <= q_b0;
    m_q_b <= q_b1;
  end

  // ---------------- scoreboard state ----------------
  logic [DW+1:0] exp_q[$];
  glog_t         g_log[$];
  logic [DW-1:0] last_rd = '0;
  int n_checks = 0;
  int n_errors = 0;
  int t0 = 0, v_last = -1, v_cnt = 0, rw_cnt = 0;
  int f_left = 0, d_left = 0, h_left = 0;
  logic d_arm = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic req_id_t gid(input logic [2:0] v);
    if (v[2]) return REQ_H;
    if (v[1]) return REQ_D;
    if (v[0]) return REQ_F;
    return REQ_NONE;
  endfunction

  task automatic push_rd(input req_id_t id, input logic [DW-1:0] data);
    exp_q.push_back({id, data});
    last_rd = data;
  endtask

  task automatic push_wr(input req_id_t id);
    exp_q.push_back({id, last_rd});
  endtask

  // One clock: observe after the edge, log grants, drop reqs, score valids.
  task automatic step();
    logic [2:0]    g;
    logic [2:0]    v;
    logic [DW+1:0] e;
    @(posedge clock);
    #1;
    g = {os.h_gnt, os.d_gnt, os.f_gnt};
    v = {os.h_valid, os.d_valid, os.f_valid};
    if (os.m_rw) rw_cnt++;
    if (g != 3'b000) begin
      check("gnt_onehot", 32'($countones(g)), 32'd1);
      g_log.push_back('{id: gid(g), rel: cyc - t0, addr: os.m_addr, data: os.m_data,
                        rw: os.m_rw, starve: os.starve});
      if (os.f_gnt && f_left > 0) begin
        f_left--;
        if (f_left == 0) f_req = 1'b0;
      end
      if (os.d_gnt && d_left > 0) begin
        d_left--;
        if (d_left == 0) d_req = 1'b0;
      end
      if (os.h_gnt && h_left > 0) begin
        h_left--;
        if (h_left == 0) begin
          h_req  = 1'b0;
          h_lock = 1'b0;
        end
      end
      if (os.h_gnt && d_arm) begin
        d_req = 1'b1;
        d_arm = 1'b0;
      end
    end
    if (v != 3'b000) begin
      v_cnt++;
      check("valid_onehot", 32'($countones(v)), 32'd1);
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'(v), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("valid_id", 32'(gid(v)), 32'(e[DW+1:DW]));
        check("rdata", 32'(os.rdata), 32'(e[DW-1:0]));
        v_last = cyc - t0;
      end
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int   n;
    logic ok;
    n  = 0;
    ok = 1'b0;
    while (n < budget && !ok) begin
      step();
      n++;
      ok = (exp_q.size() == 0) && !f_req && !d_req && !h_req && (os.st == IDLE);
    end
    check({tag, "_complete"}, 32'(ok), 32'd1);
    if (!ok) begin
      exp_q.delete();
      f_req = 1'b0;
      d_req = 1'b0;
      h_req = 1'b0;
    end
  endtask

  task automatic expect_grant(input string tag, input int k, input req_id_t id, input int rel);
    if (g_log.size() <= k) begin
      check({tag, "_missing"}, 32'(g_log.size()), 32'(k + 1));
    end else begin
      check({tag, "_id"}, 32'(g_log[k].id), 32'(id));
      check({tag, "_cyc"}, 32'(g_log[k].rel), 32'(rel));
    end
  endtask

  task automatic begin_txn();
    g_log.delete();
    t0     = cyc;
    v_last = -1;
    v_cnt  = 0;
    rw_cnt = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1; sel = 1'b0;
    f_req = 1'b0; d_req = 1'b0; h_req = 1'b0; d_we = 1'b0; h_we = 1'b0; h_lock = 1'b0;
    f_addr = '0; d_addr = '0; h_addr = '0; d_wdata = '0; h_wdata = '0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    step();
    bd_we = 1'b1; bd_addr = 12'h005; bd_data = 16'hBEEF; step();
    bd_addr = 12'hFFF; bd_data = 16'hCAFE; step();
    bd_addr = 12'h033; bd_data = 16'h5A5A; step();
    bd_we = 1'b0; step();

    // Reset values while reset is held.
    check("rst_gnts", 32'({os.f_gnt, os.d_gnt, os.h_gnt}), 32'd0);
    check("rst_valids", 32'({os.f_valid, os.d_valid, os.h_valid}), 32'd0);
    check("rst_m_rw", 32'(os.m_rw), 32'd0);
    check("rst_m_addr", 32'(os.m_addr), 32'd0);
    check("rst_m_data", 32'(os.m_data), 32'd0);
    check("rst_rdata", 32'(os.rdata), 32'd0);
    check("rst_state", 32'(os.st), 32'(IDLE));
    check("rst_starve", 32'(os.starve), 32'd0);

    // Fetch read in the first cycle reset is low.
    reset = 1'b0;
    begin_txn();
    push_rd(REQ_F, 16'hBEEF);
    f_addr = 12'h005; f_req = 1'b1; f_left = 1;
    wait_idle("t1", 30);
    expect_grant("t1_g0", 0, REQ_F, 1);
    if (g_log.size() > 0) begin
      check("t1_m_addr", 32'(g_log[0].addr), 32'h005);
      check("t1_m_rw", 32'(g_log[0].rw), 32'd0);
    end
    check("t1_valid_cyc", 32'(v_last), 32'd3);

    // Data write, then fetch the written word back.
    begin_txn();
    push_wr(REQ_D);
    d_we = 1'b1; d_addr = 12'h0A0; d_wdata = 16'h1234; d_req = 1'b1; d_left = 1;
    wait_idle("t2w", 30);
    expect_grant("t2_g0", 0, REQ_D, 1);
    if (g_log.size() > 0) begin
      check("t2_m_addr", 32'(g_log[0].addr), 32'h0A0);
      check("t2_m_data", 32'(g_log[0].data), 32'h1234);
      check("t2_m_rw", 32'(g_log[0].rw), 32'd1);
    end
    check("t2_rw_cycles", 32'(rw_cnt), 32'd1);
    check("t2_valid_cyc", 32'(v_last), 32'd3);
    d_we = 1'b0;
    begin_txn();
    push_rd(REQ_F, 16'h1234);
    f_addr = 12'h0A0; f_req = 1'b1; f_left = 1;
    wait_idle("t2r", 30);
    expect_grant("t2r_g0", 0, REQ_F, 1);

    // Three simultaneous requests: D, H, F in turn.
    begin_txn();
    push_rd(REQ_D, 16'hCAFE);
    push_rd(REQ_H, 16'h5A5A);
    push_rd(REQ_F, 16'hBEEF);
    d_addr = 12'hFFF; h_addr = 12'h033; f_addr = 12'h005;
    d_req = 1'b1; h_req = 1'b1; f_req = 1'b1;
    d_left = 1; h_left = 1; f_left = 1;
    wait_idle("t3", 60);
    expect_grant("t3_g0", 0, REQ_D, 1);
    expect_grant("t3_g1", 1, REQ_H, 4);
    expect_grant("t3_g2", 2, REQ_F, 7);
    if (g_log.size() > 0) check("t3_top_addr", 32'(g_log[0].addr), 32'hFFF);

    // Starvation override with STARVE_LIMIT=2.
    begin_txn();
    push_rd(REQ_D, 16'hCAFE);
    push_rd(REQ_D, 16'hCAFE);
    push_rd(REQ_F, 16'hBEEF);
    push_rd(REQ_D, 16'hCAFE);
    d_addr = 12'hFFF; f_addr = 12'h005;
    d_req = 1'b1; f_req = 1'b1; d_left = 3; f_left = 1;
    wait_idle("t4", 60);
    expect_grant("t4_g0", 0, REQ_D, 1);
    expect_grant("t4_g1", 1, REQ_D, 4);
    expect_grant("t4_g2", 2, REQ_F, 7);
    expect_grant("t4_g3", 3, REQ_D, 10);
    if (g_log.size() > 2) begin
      check("t4_starve_before", 32'(g_log[1].starve), 32'd2);
      check("t4_starve_cleared", 32'(g_log[2].starve), 32'd0);
    end
    check("t4_starve_end", 32'(os.starve), 32'd0);

    // Host lock beats D for four transfers, then D gets through.
    begin_txn();
    for (int i = 0; i < 4; i++) push_rd(REQ_H, 16'h5A5A);
    push_rd(REQ_D, 16'hCAFE);
    h_addr = 12'h033; d_addr = 12'hFFF;
    h_req = 1'b1; h_lock = 1'b1; h_left = 4; d_arm = 1'b1; d_left = 1;
    wait_idle("t5", 80);
    expect_grant("t5_g0", 0, REQ_H, 1);
    expect_grant("t5_g1", 1, REQ_H, 4);
    expect_grant("t5_g2", 2, REQ_H, 7);
    expect_grant("t5_g3", 3, REQ_H, 10);
    expect_grant("t5_g4", 4, REQ_D, 13);

    // MEM_LATENCY=3: reset during WAIT aborts the D read.
    sel = 1'b1;
    begin_txn();
    d_addr = 12'h005; d_we = 1'b0; d_req = 1'b1; d_left = 1;
    step();
    step();
    expect_grant("t6_g0", 0, REQ_D, 1);
    check("t6_in_wait", 32'(os.st), 32'(WAIT));
    reset = 1'b1;
    step();
    check("t6_rst_m_rw", 32'(os.m_rw), 32'd0);
    check("t6_rst_state", 32'(os.st), 32'(IDLE));
    check("t6_rst_m_addr", 32'(os.m_addr), 32'd0);
    check("t6_rst_rdata", 32'(os.rdata), 32'd0);
    check("t6_rst_pulses", 32'({os.f_gnt, os.d_gnt, os.h_gnt, os.f_valid, os.d_valid, os.h_valid}), 32'd0);
    reset = 1'b0;
    repeat (6) step();
    check("t6_no_valid", 32'(v_cnt), 32'd0);
    begin_txn();
    push_rd(REQ_F, 16'hBEEF);
    f_addr = 12'h005; f_req = 1'b1; f_left = 1;
    wait_idle("t6f", 40);
    expect_grant("t6f_g0", 0, REQ_F, 1);
    check("t6f_valid_cyc", 32'(v_last), 32'd5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
